// File: rtl/scan_decoder_pkg.sv
//------------------------------------------------------------------------------
// Module   : scan_decoder_pkg
// Brief    : Shared types and the one-hot helper for the scanning decoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package scan_decoder_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Widest select the helper supports; callers cast the result down to OUT_W.
    localparam int MAX_IN_W  = 8;
    localparam int MAX_OUT_W = 1 << MAX_IN_W;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IN_W-1:0] sel);
        logic [MAX_OUT_W-1:0] vec;
        vec      = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dwell_counter.sv
//------------------------------------------------------------------------------
// Module   : dwell_counter
// Brief    : Counts 0..div with enable and synchronous clear; tc flags the last count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dwell_counter
    import scan_decoder_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic             clka,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tc
);

    logic [DIV_W-1:0] dwell;

    // >= rather than == so a div lowered mid-dwell takes effect on the next edge.
    assign tc = (dwell >= div);

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            dwell <= '0;
        end else if (clr) begin
            dwell <= '0;
        end else if (en) begin
            if (tc) begin
                dwell <= '0;
            end else begin
                dwell <= dwell + DIV_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/scan_decoder_n.sv
//------------------------------------------------------------------------------
// Module   : scan_decoder_n
// Brief    : Registered N-to-2^N one-hot decoder with direct and dwell-timed scan modes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module scan_decoder_n
    import scan_decoder_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int OUT_W = 2**IN_W,
    parameter int DIV_W = 4
) (
    input  logic             clka,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [IN_W-1:0]  sel_in,
    input  logic [DIV_W-1:0] div,
    output logic [OUT_W-1:0] out,
    output logic [IN_W-1:0]  idx,
    output logic             wrap
);

    mode_e            mode_q;
    logic             load_sel;
    logic             scan_run;
    logic             tc;
    logic             step;
    logic [IN_W-1:0]  idx_next;
    logic [OUT_W-1:0] out_next;
    logic             wrap_next;

    // Direct mode and the first scan cycle both take the index from sel_in.
    assign load_sel = (mode_e'(mode) == MODE_DIRECT) || (mode_q == MODE_DIRECT);
    assign scan_run = !load_sel && en;
    assign step     = scan_run && tc;

    dwell_counter #(
        .DIV_W (DIV_W)
    ) u_dwell (
        .clka  (clka),
        .rst_n (rst_n),
        .en    (scan_run),
        .clr   (load_sel),
        .div   (div),
        .tc    (tc)
    );

    always_comb begin
        idx_next  = idx;
        wrap_next = 1'b0;
        if (load_sel) begin
            idx_next = sel_in;
        end else if (step) begin
            idx_next  = idx + IN_W'(1);
            wrap_next = (idx == IN_W'(OUT_W - 1));
        end
        out_next = en ? OUT_W'(onehot(MAX_IN_W'(idx_next))) : '0;
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            out    <= '0;
            idx    <= '0;
            wrap   <= 1'b0;
            mode_q <= MODE_DIRECT;
        end else begin
            out    <= out_next;
            idx    <= idx_next;
            wrap   <= wrap_next;
            mode_q <= mode_e'(mode);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scan_decoder_n.sv
//------------------------------------------------------------------------------
// Module   : tb_scan_decoder_n
// Brief    : Directed vector bench for scan_decoder_n (IN_W=3, DIV_W=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_scan_decoder_n;

    typedef struct {
        logic       en;
        logic       mode;
        logic [2:0] sel;
        logic [3:0] div;
        logic [7:0] exp_out;
        logic [2:0] exp_idx;
        logic       exp_wrap;
    } vec_t;

    logic       clka;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] sel_in;
    logic [3:0] div;
    logic [7:0] out;
    logic [2:0] idx;
    logic       wrap;

    int compared   = 0;
    int mismatched = 0;
    vec_t vecs[$];

    scan_decoder_n #(
        .IN_W  (3),
        .DIV_W (4)
    ) dut (
        .clka   (clka),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode),
        .sel_in (sel_in),
        .div    (div),
        .out    (out),
        .idx    (idx),
        .wrap   (wrap)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic add(input logic e, input logic m, input logic [2:0] s, input logic [3:0] d,
                       input logic [7:0] o, input logic [2:0] i, input logic w);
        vec_t v;
        v.en = e; v.mode = m; v.sel = s; v.div = d;
        v.exp_out = o; v.exp_idx = i; v.exp_wrap = w;
        vecs.push_back(v);
    endtask

    task automatic check_all(input string name, input logic [7:0] o, input logic [2:0] i,
                             input logic w);
        compared++;
        if (out !== o || idx !== i || wrap !== w) begin
            mismatched++;
            $display("FAIL %s: got out=%h idx=%0d wrap=%b, want out=%h idx=%0d wrap=%b",
                     name, out, idx, wrap, o, i, w);
        end
    endtask

    task automatic step(input logic e, input logic m, input logic [2:0] s, input logic [3:0] d);
        @(negedge clka);
        en = e; mode = m; sel_in = s; div = d;
        @(posedge clka);
        #1;
    endtask

    initial begin
        // Direct decode and direct with en=0
        add(1, 0, 5, 0, 8'h20, 5, 0);
        add(0, 0, 3, 0, 8'h00, 3, 0);
        add(1, 0, 3, 0, 8'h08, 3, 0);
        // Scan div=0 from 6: wrap on each arrival at 0, 8 cycles apart
        add(1, 1, 6, 0, 8'h40, 6, 0);
        add(1, 1, 0, 0, 8'h80, 7, 0);
        add(1, 1, 0, 0, 8'h01, 0, 1);
        add(1, 1, 0, 0, 8'h02, 1, 0);
        add(1, 1, 0, 0, 8'h04, 2, 0);
        add(1, 1, 0, 0, 8'h08, 3, 0);
        add(1, 1, 0, 0, 8'h10, 4, 0);
        add(1, 1, 0, 0, 8'h20, 5, 0);
        add(1, 1, 0, 0, 8'h40, 6, 0);
        add(1, 1, 0, 0, 8'h80, 7, 0);
        add(1, 1, 0, 0, 8'h01, 0, 1);
        // div=2: three cycles per position
        add(1, 1, 0, 2, 8'h01, 0, 0);
        add(1, 1, 0, 2, 8'h01, 0, 0);
        add(1, 1, 0, 2, 8'h02, 1, 0);
        add(1, 1, 0, 2, 8'h02, 1, 0);
        add(1, 1, 0, 2, 8'h02, 1, 0);
        add(1, 1, 0, 2, 8'h04, 2, 0);
        add(1, 1, 0, 2, 8'h04, 2, 0);
        // dwell=1, div lowered to 1: advance on this edge, then 2-cycle positions
        add(1, 1, 0, 1, 8'h08, 3, 0);
        add(1, 1, 0, 1, 8'h08, 3, 0);
        add(1, 1, 0, 1, 8'h10, 4, 0);
        // back to div=2, dwell reaches 1 at idx 4, then freeze 5 cycles
        add(1, 1, 0, 2, 8'h10, 4, 0);
        for (int k = 0; k < 5; k++) add(0, 1, 0, 2, 8'h00, 4, 0);
        add(1, 1, 0, 2, 8'h10, 4, 0);
        add(1, 1, 0, 2, 8'h20, 5, 0);
        add(1, 1, 0, 2, 8'h20, 5, 0);
        add(1, 1, 0, 2, 8'h20, 5, 0);
        add(1, 1, 0, 2, 8'h40, 6, 0);
        add(1, 1, 0, 2, 8'h40, 6, 0);
        add(1, 1, 0, 2, 8'h40, 6, 0);
        add(1, 1, 0, 2, 8'h80, 7, 0);
        add(1, 1, 0, 2, 8'h80, 7, 0);
        add(1, 1, 0, 2, 8'h80, 7, 0);
        add(1, 1, 0, 2, 8'h01, 0, 1);
        // Mode exit returns to direct decode
        add(1, 0, 1, 2, 8'h02, 1, 0);
        add(1, 0, 7, 2, 8'h80, 7, 0);

        rst_n = 1'b1; en = 1'b1; mode = 1'b0; sel_in = 3'd2; div = 4'd0;
        @(posedge clka);
        @(negedge clka);
        #2 rst_n = 1'b0;
        #1 check_all("async_reset", 8'h00, 3'd0, 1'b0);
        @(posedge clka);
        #1 check_all("reset_held", 8'h00, 3'd0, 1'b0);
        @(negedge clka);
        rst_n = 1'b1;

        foreach (vecs[n]) begin
            step(vecs[n].en, vecs[n].mode, vecs[n].sel, vecs[n].div);
            check_all($sformatf("vec%0d", n), vecs[n].exp_out, vecs[n].exp_idx, vecs[n].exp_wrap);
        end

        // Reset mid-scan at idx 7, then restart from sel_in with mode still high
        step(1, 1, 7, 3);
        check_all("scan_entry7", 8'h80, 3'd7, 1'b0);
        step(1, 1, 0, 3);
        check_all("scan_hold7", 8'h80, 3'd7, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_all("reset_midscan", 8'h00, 3'd0, 1'b0);
        @(negedge clka);
        en = 1'b1; mode = 1'b1; sel_in = 3'd2; div = 4'd0;
        rst_n = 1'b1;
        @(posedge clka);
        #1 check_all("restart_entry", 8'h04, 3'd2, 1'b0);
        step(1, 1, 0, 0);
        check_all("restart_step", 8'h08, 3'd3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
